// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared steering selects, FSM encoding and latency-counter width.
package mem_port_arbiter_pkg;
  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;
  localparam int   CNT_W   = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: two-requester picker that alternates priority on contention.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_if,
  input  logic req_mem,
  output logic gnt_valid,
  output logic gnt_sel
);
  logic last_gnt_q, last_gnt_d;
  always_comb begin
    gnt_valid  = en & (req_if | req_mem);
    gnt_sel    = (req_if & req_mem) ? ((last_gnt_q == SEL_IF) ? SEL_MEM : SEL_IF)
                                    : (req_mem ? SEL_MEM : SEL_IF);
    last_gnt_d = gnt_valid ? gnt_sel : last_gnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_gnt_q <= SEL_IF;
    else     last_gnt_q <= last_gnt_d;
  end
endmodule

// File: rtl/mux2to1.sv
// Mux2to1: generic two-input steering multiplexer.
module Mux2to1 #(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  sel,
  input  logic [WIDTH_DATA-1:0] in0,
  input  logic [WIDTH_DATA-1:0] in1,
  output logic [WIDTH_DATA-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency RAM port between instruction fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d, en_q, en_d, we_q, we_d;
  logic             if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic             at_done, arb_en, el_if, el_mem, gnt_valid, gnt_sel;

  // The completing requester drops its req next cycle, so it is not eligible in DONE.
  assign at_done = state_q == DONE;
  assign arb_en  = (state_q == IDLE) | at_done;
  assign el_if   = if_req & ~(at_done & (sel_q == SEL_IF));
  assign el_mem  = mem_req & ~(at_done & (sel_q == SEL_MEM));

  arb_rr2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (arb_en),
    .req_if   (el_if),
    .req_mem  (el_mem),
    .gnt_valid(gnt_valid),
    .gnt_sel  (gnt_sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = gnt_valid ? ISSUE : IDLE;
        sel_d   = gnt_valid ? gnt_sel : sel_q;
      end
      ISSUE: begin
        state_d = (MEM_LAT == 1) ? DONE : WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        state_d = (cnt_q == CNT_W'(1)) ? DONE : WAIT;
        cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
    en_d       = state_d == ISSUE;
    we_d       = en_d & (sel_d == SEL_MEM) & mem_we;
    if_done_d  = (state_d == DONE) & (sel_d == SEL_IF);
    mem_done_d = (state_d == DONE) & (sel_d == SEL_MEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= SEL_IF;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      we_q       <= we_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  Mux2to1 #(.WIDTH_DATA(ADDR_W)) u_addr_mux (
    .sel(sel_q), .in0(if_addr), .in1(mem_addr), .out(ram_addr)
  );
  Mux2to1 #(.WIDTH_DATA(DATA_W)) u_wdata_mux (
    .sel(sel_q), .in0({DATA_W{1'b0}}), .in1(mem_wdata), .out(ram_wdata)
  );

  assign ram_en    = en_q;
  assign ram_we    = we_q;
  assign ram_sel   = sel_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic        if_done, mem_done, ram_en, ram_we, ram_sel, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

  logic        l_if_req, l_mem_req, l_mem_we;
  logic [31:0] l_if_addr, l_mem_addr, l_mem_wdata, l_ram_rdata;
  logic        l_if_done, l_mem_done, l_ram_en, l_ram_we, l_ram_sel, l_stall_if, l_stall_mem;
  logic [31:0] l_if_rdata, l_mem_rdata, l_ram_addr, l_ram_wdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .if_req(l_if_req), .if_addr(l_if_addr), .if_done(l_if_done), .if_rdata(l_if_rdata),
    .mem_req(l_mem_req), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_done(l_mem_done), .mem_rdata(l_mem_rdata), .ram_en(l_ram_en), .ram_we(l_ram_we), .ram_sel(l_ram_sel),
    .ram_addr(l_ram_addr), .ram_wdata(l_ram_wdata), .ram_rdata(l_ram_rdata),
    .stall_if(l_stall_if), .stall_mem(l_stall_mem)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0;
    l_if_req = 0; l_mem_req = 0; l_mem_we = 0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_req = 1; mem_req = 0; mem_we = 0;
    step;
    step;
    @(negedge clk);
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL reset ram_en got %b exp 0", ram_en); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset ram_we got %b exp 0", ram_we); end
    vectors++; if (ram_sel !== 1'b0) begin miscompares++; $display("FAIL reset ram_sel got %b exp 0", ram_sel); end
    vectors++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b%b exp 00", if_done, mem_done); end
    vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin miscompares++; $display("FAIL reset stalls got %b%b exp 10", stall_if, stall_mem); end
    if_req = 0;
    step;
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    do_reset;
    if_req = 1; if_addr = 32'h0040_0000;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) if_req = 0;
      ram_rdata = $urandom;
      @(negedge clk);
      vectors++; if (ram_en !== (c == 1)) begin miscompares++; $display("FAIL fetch ram_en c=%0d got %b exp %b", c, ram_en, c == 1); end
      vectors++; if (if_done !== (c == 3)) begin miscompares++; $display("FAIL fetch if_done c=%0d got %b exp %b", c, if_done, c == 3); end
      vectors++; if (stall_if !== (c < 3)) begin miscompares++; $display("FAIL fetch stall_if c=%0d got %b exp %b", c, stall_if, c < 3); end
      if (c == 1) begin
        vectors++; if (ram_sel !== 1'b0 || ram_addr !== 32'h0040_0000) begin miscompares++; $display("FAIL fetch steer got sel=%b addr=%h exp sel=0 addr=00400000", ram_sel, ram_addr); end
      end
      if (c == 3) begin
        vectors++; if (if_rdata !== ram_rdata) begin miscompares++; $display("FAIL fetch if_rdata got %h exp %h", if_rdata, ram_rdata); end
      end
      step;
    end
  endtask

  task automatic test_fairness;
    int run, max_run;
    run = 0; max_run = 0;
    do_reset;
    if_req = 1; if_addr = 32'h0040_0100;
    mem_req = 1; mem_we = 0; mem_addr = 32'h1001_0000;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      vectors++; if (ram_en !== (c % 3 == 1)) begin miscompares++; $display("FAIL fair ram_en c=%0d got %b exp %b", c, ram_en, c % 3 == 1); end
      if (c % 3 == 1) begin
        vectors++; if (ram_sel !== ((c / 3) % 2 == 0)) begin miscompares++; $display("FAIL fair ram_sel c=%0d got %b exp %b", c, ram_sel, (c / 3) % 2 == 0); end
      end
      vectors++; if (mem_done !== (c > 0 && c % 3 == 0 && (c / 3) % 2 == 1)) begin miscompares++; $display("FAIL fair mem_done c=%0d got %b", c, mem_done); end
      vectors++; if (if_done !== (c > 0 && c % 3 == 0 && (c / 3) % 2 == 0)) begin miscompares++; $display("FAIL fair if_done c=%0d got %b", c, if_done); end
      run = stall_if ? run + 1 : 0;
      if (run > max_run) max_run = run;
      step;
    end
    vectors++; if (max_run > 6) begin miscompares++; $display("FAIL fair if_wait got %0d exp <=6", max_run); end
    if_req = 0; mem_req = 0;
  endtask

  task automatic test_store;
    do_reset;
    mem_req = 1; mem_we = 1; mem_addr = 32'h1001_0004; mem_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin mem_req = 0; mem_we = 0; end
      @(negedge clk);
      vectors++; if (ram_we !== (c == 1)) begin miscompares++; $display("FAIL store ram_we c=%0d got %b exp %b", c, ram_we, c == 1); end
      vectors++; if (mem_done !== (c == 3)) begin miscompares++; $display("FAIL store mem_done c=%0d got %b exp %b", c, mem_done, c == 3); end
      if (c == 1) begin
        vectors++; if (ram_sel !== 1'b1 || ram_wdata !== 32'hDEAD_BEEF || ram_addr !== 32'h1001_0004) begin miscompares++; $display("FAIL store steer got sel=%b addr=%h wdata=%h", ram_sel, ram_addr, ram_wdata); end
      end
      step;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    if_req = 1; if_addr = 32'h0040_0200;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      vectors++; if (ram_en !== (c == 1 || c == 4)) begin miscompares++; $display("FAIL rstmid ram_en c=%0d got %b exp %b", c, ram_en, c == 1 || c == 4); end
      vectors++; if (if_done !== (c == 6)) begin miscompares++; $display("FAIL rstmid if_done c=%0d got %b exp %b", c, if_done, c == 6); end
      vectors++; if (stall_if !== (c != 6)) begin miscompares++; $display("FAIL rstmid stall_if c=%0d got %b exp %b", c, stall_if, c != 6); end
      step;
    end
    if_req = 0;
    step;
  endtask

  task automatic test_lat1;
    do_reset;
    l_mem_req = 1; l_mem_we = 0; l_mem_addr = 32'h1001_0040; l_mem_wdata = 32'h1234_5678;
    l_if_req = 1; l_if_addr = 32'h0040_0040;
    for (int c = 0; c < 7; c++) begin
      l_ram_rdata = $urandom;
      @(negedge clk);
      vectors++; if (l_ram_en !== (c % 2 == 1)) begin miscompares++; $display("FAIL lat1 ram_en c=%0d got %b exp %b", c, l_ram_en, c % 2 == 1); end
      vectors++; if (l_ram_we !== 1'b0) begin miscompares++; $display("FAIL lat1 ram_we c=%0d got %b exp 0", c, l_ram_we); end
      vectors++; if (l_mem_done !== (c % 4 == 2)) begin miscompares++; $display("FAIL lat1 mem_done c=%0d got %b exp %b", c, l_mem_done, c % 4 == 2); end
      vectors++; if (l_if_done !== (c == 4)) begin miscompares++; $display("FAIL lat1 if_done c=%0d got %b exp %b", c, l_if_done, c == 4); end
      vectors++; if (l_stall_mem !== (c % 4 != 2) || l_stall_if !== (c != 4)) begin miscompares++; $display("FAIL lat1 stalls c=%0d got %b%b", c, l_stall_if, l_stall_mem); end
      if (c % 2 == 1) begin
        vectors++; if (l_ram_sel !== ((c / 2) % 2 == 0) || l_ram_addr !== (((c / 2) % 2 == 0) ? l_mem_addr : l_if_addr)) begin miscompares++; $display("FAIL lat1 steer c=%0d got sel=%b addr=%h", c, l_ram_sel, l_ram_addr); end
        if ((c / 2) % 2 == 0) begin
          vectors++; if (l_ram_wdata !== l_mem_wdata) begin miscompares++; $display("FAIL lat1 wdata got %h exp %h", l_ram_wdata, l_mem_wdata); end
        end
      end
      if (l_mem_done) begin
        vectors++; if (l_mem_rdata !== l_ram_rdata) begin miscompares++; $display("FAIL lat1 mem_rdata got %h exp %h", l_mem_rdata, l_ram_rdata); end
      end
      if (l_if_done) begin
        vectors++; if (l_if_rdata !== l_ram_rdata) begin miscompares++; $display("FAIL lat1 if_rdata got %h exp %h", l_if_rdata, l_ram_rdata); end
      end
      step;
    end
    l_mem_req = 0; l_if_req = 0;
  endtask

  // Model: an access is issued the cycle after its grant and completes LAT cycles after issue.
  task automatic test_random;
    bit busy, who, last, drop_if, drop_mem, e_en, e_done, e_if_done, e_mem_done, el_if, el_mem, g;
    int age;
    busy = 0; who = 0; last = 0; drop_if = 0; drop_mem = 0; age = 0;
    do_reset;
    for (int n = 0; n < 400; n++) begin
      if (drop_if) if_req = 0;
      else if (!if_req && $urandom % 3 == 0) begin if_req = 1; if_addr = $urandom; end
      if (drop_mem) begin mem_req = 0; mem_we = 0; end
      else if (!mem_req && $urandom % 3 == 0) begin mem_req = 1; mem_we = $urandom % 2; mem_addr = $urandom; mem_wdata = $urandom; end
      ram_rdata = $urandom;
      e_en = busy && age == 1;
      e_done = busy && age == LAT + 1;
      e_if_done = e_done && !who;
      e_mem_done = e_done && who;
      @(negedge clk);
      vectors++; if (ram_en !== e_en) begin miscompares++; $display("FAIL rand ram_en n=%0d got %b exp %b", n, ram_en, e_en); end
      vectors++; if (ram_we !== (e_en && who && mem_we)) begin miscompares++; $display("FAIL rand ram_we n=%0d got %b exp %b", n, ram_we, e_en && who && mem_we); end
      vectors++; if (if_done !== e_if_done || mem_done !== e_mem_done) begin miscompares++; $display("FAIL rand done n=%0d got %b%b exp %b%b", n, if_done, mem_done, e_if_done, e_mem_done); end
      vectors++; if (stall_if !== (if_req && !e_if_done) || stall_mem !== (mem_req && !e_mem_done)) begin miscompares++; $display("FAIL rand stalls n=%0d got %b%b", n, stall_if, stall_mem); end
      if (e_en) begin
        vectors++; if (ram_sel !== who || ram_addr !== (who ? mem_addr : if_addr)) begin miscompares++; $display("FAIL rand steer n=%0d got sel=%b addr=%h exp sel=%b", n, ram_sel, ram_addr, who); end
        if (who) begin
          vectors++; if (ram_wdata !== mem_wdata) begin miscompares++; $display("FAIL rand wdata n=%0d got %h exp %h", n, ram_wdata, mem_wdata); end
        end
      end
      if (e_if_done) begin
        vectors++; if (if_rdata !== ram_rdata) begin miscompares++; $display("FAIL rand if_rdata n=%0d got %h exp %h", n, if_rdata, ram_rdata); end
      end
      if (e_mem_done && !mem_we) begin
        vectors++; if (mem_rdata !== ram_rdata) begin miscompares++; $display("FAIL rand mem_rdata n=%0d got %h exp %h", n, mem_rdata, ram_rdata); end
      end
      drop_if = e_if_done;
      drop_mem = e_mem_done;
      el_if = if_req && !e_if_done;
      el_mem = mem_req && !e_mem_done;
      if (!busy || e_done) begin
        if (el_if || el_mem) begin
          g = (el_if && el_mem) ? !last : el_mem;
          busy = 1; who = g; age = 1; last = g;
        end else busy = 0;
      end else age++;
      step;
    end
    if_req = 0; mem_req = 0;
  endtask

  initial begin
    rst = 1; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
    l_if_req = 0; l_mem_req = 0; l_mem_we = 0;
    l_if_addr = 0; l_mem_addr = 0; l_mem_wdata = 0; l_ram_rdata = 0;
    test_reset;
    test_single_fetch;
    test_fairness;
    test_store;
    test_reset_mid;
    test_lat1;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one access at a time and drives the 2:1 address/wdata steering select.
- Sequences the fixed RAM read latency, returns data with a one-cycle done pulse, and produces the stall signals the hazard logic consumes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from RAM enable to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched word.
- mem_req  in  1  load/store request; level, held until mem_done.
- mem_we  in  1  1 = store; stable while mem_req.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_W  load data, valid with mem_done.
- ram_en  out  1  RAM access strobe, one cycle per access.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_sel  out  1  steering select: 0 = IF, 1 = MEM.
- ram_addr  out  ADDR_W  steered address.
- ram_wdata  out  DATA_W  steered write data.
- ram_rdata  in  DATA_W  RAM read data.
- stall_if  out  1  if_req & ~if_done.
- stall_mem  out  1  mem_req & ~mem_done.

Behaviour:
- Reset state: clk and rst are synchronous; rst is active-high.
  - On rst, all registered state clears: state=IDLE, ram_en=0, ram_we=0, ram_sel=0, cnt=0, last_gnt=IF.
  - if_done=0 and mem_done=0.
- FSM states:
  - IDLE: no access in flight.
  - ISSUE: ram_en=1 for exactly one cycle.
  - WAIT: cnt counts down from MEM_LAT-1.
  - DONE: done pulse to the granted requester.
  - With MEM_LAT=1, WAIT is skipped (ISSUE -> DONE).
- Arbitration happens in IDLE or DONE and uses the eligible requests.
  - In DONE, the completing requester's req is masked, because that requester drops it next cycle.
  - Only one eligible request: grant it.
  - Both eligible: grant MEM if last_gnt==IF, else grant IF. This alternates, so neither starves.
  - last_gnt updates on each grant.
  - A grant moves the FSM to ISSUE next cycle. No eligible request moves it to IDLE.
- Timing: grant decided in cycle T; ISSUE in T+1; done pulse in T+1+MEM_LAT.
  - Back-to-back accesses: one access per MEM_LAT+1 cycles.
- ram_sel is registered at grant and held constant from ISSUE through DONE.
- ram_addr and ram_wdata come from a Mux2to1 on ram_sel. ram_we = mem_we in ISSUE when ram_sel=1, else 0.
- Stores use the same latency as loads. mem_rdata is don't-care on a store.
- if_rdata and mem_rdata are both driven from ram_rdata. Each is meaningful only with its done pulse.
- A requester deasserting req mid-access is a protocol violation. The access still completes and the done pulse is still issued.
- rst mid-access: FSM returns to IDLE, no done pulse, in-flight RAM read discarded, stalls follow the req inputs.

Decomposition:
- Shared package holds:
  - SEL_IF=1'b0 and SEL_MEM=1'b1.
  - The FSM state encoding, 2 bits: IDLE, ISSUE, WAIT, DONE.
  - The 3-bit latency-counter width constant.
- Natural sub-module: arb_rr2, a 2-requester alternating-priority picker holding the last_gnt flag.
- Address/wdata steering reuses the existing Mux2to1 (WIDTH_DATA=ADDR_W / DATA_W).

Test Plan (MEM_LAT=2):
- Single fetch: if_req=1, if_addr=0x00400000 at cycle 0.
  - Cycle 1: ram_en=1, ram_sel=0, ram_addr=0x00400000.
  - Cycle 3: if_done=1, if_rdata=ram_rdata.
  - stall_if=1 in cycles 0-2.
- Simultaneous requests: both req from reset, with last_gnt=IF after reset.
  - MEM issues first: cycle 1, done at cycle 3.
  - IF issues at cycle 4, if_done at cycle 6.
- Store: mem_we=1, mem_addr=0x10010004, mem_wdata=0xDEADBEEF.
  - ISSUE cycle: ram_we=1, ram_sel=1, ram_wdata=0xDEADBEEF.
  - mem_done 2 cycles later; ram_we=0 in every other cycle.
- Fairness: both requests held continuously for 12 cycles.
  - Grants alternate MEM, IF, MEM, IF, one ISSUE every 3 cycles.
  - No requester waits more than 6 cycles.
- Reset mid-access: rst=1 in the WAIT cycle of an IF access.
  - No if_done follows; next cycle state=IDLE, ram_en=0.
  - After rst drops with if_req held, re-issue occurs one cycle later.
- MEM_LAT=1 build: single load.
  - ISSUE in cycle 1, mem_done in cycle 2.
  - Back-to-back loads issue every 2 cycles.
